game_controller: RTL and testbench

Sequences one round of the attack game around `map_decoder`. It latches the player's 3-bit map selection, enables the decoder, and counts the ships in the returned 35-pixel map. It then resolves (column, row) attacks against that map, tracking hits, misses and remaining attempts until the round is won or lost. It sits between the board's buttons/switches and the decoder and LED-matrix display logic.

---
 rtl/game_controller.sv | 165 ++++++++++++++++
 tb/tb_game_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// One round of the attack game: latch a map code, count ships from map_decoder, resolve attacks.
// Optional REPEAT_ATTACK_PENALTY_EN: a repeat attack costs an attempt instead of being rejected.
module game_controller #(
  parameter int DATA_WIDTH    = 35,
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int MAX_ATTEMPTS  = 10,
  parameter int ATTEMPT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               codeInput,
  input  logic                     confirm,
  input  logic                     attackButton,
  input  logic [2:0]               column,
  input  logic [2:0]               row,
  input  logic [DATA_WIDTH-1:0]    mapIn,
  output logic [2:0]               mapCode,
  output logic                     mapEnable,
  output logic [DATA_WIDTH-1:0]    hitMap,
  output logic [DATA_WIDTH-1:0]    missMap,
  output logic [ATTEMPT_WIDTH-1:0] attemptsLeft,
  output logic [5:0]               hitCount,
  output logic                     playing,
  output logic                     win,
  output logic                     lose,
  output logic                     lastHit,
  output logic                     lastMiss,
  output logic                     invalidAttack
);

  typedef enum logic [2:0] {SETUP, LOAD, PLAY, RESOLVE, WIN, LOSE} state_t;

  state_t                   state, next_state;
  logic                     confirm_prev, attack_prev;
  logic                     confirm_edge, attack_edge;
  logic [5:0]               total_ships, zero_count;
  logic [5:0]               idx, attack_idx;
  logic [DATA_WIDTH-1:0]    attacked;
  logic                     coord_ok, already_set, repeat_q;
  logic                     start_round, accept_attack, reject_attack, resolve_hit;
  logic [5:0]               hit_count_next;
  logic [ATTEMPT_WIDTH-1:0] attempts_next;

  assign confirm_edge = confirm & ~confirm_prev;
  assign attack_edge  = attackButton & ~attack_prev;
  assign attacked     = hitMap | missMap;
  assign coord_ok     = (column < 3'(TOTAL_COLUNES)) && (row != 3'd0);
  assign attack_idx   = {3'b000, column} * 6'(COLUNE_SIZE) + {3'b000, row} - 6'd1;
  assign already_set  = coord_ok && attacked[attack_idx];

  always_comb begin
    zero_count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) zero_count = zero_count + {5'b0, ~mapIn[i]};
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state     = state;
    mapEnable      = 1'b1;
    playing        = 1'b0;
    win            = 1'b0;
    lose           = 1'b0;
    start_round    = 1'b0;
    accept_attack  = 1'b0;
    reject_attack  = 1'b0;
    resolve_hit    = ~mapIn[idx] & ~repeat_q;
    hit_count_next = hitCount;
    attempts_next  = attemptsLeft;
    case (state)
      SETUP: begin
        mapEnable = 1'b0;
        if (confirm_edge) begin
          start_round = 1'b1;
          next_state  = LOAD;
        end
      end
      LOAD: next_state = (zero_count == 6'd0) ? WIN : PLAY;
      PLAY: begin
        playing = 1'b1;
        if (attack_edge) begin
`ifdef REPEAT_ATTACK_PENALTY_EN
          accept_attack = coord_ok;
`else
          accept_attack = coord_ok && !already_set;
`endif
          reject_attack = !accept_attack;
          if (accept_attack) next_state = RESOLVE;
        end
      end
      RESOLVE: begin
        if (resolve_hit) hit_count_next = hitCount + 6'd1;
        else if (attemptsLeft != '0) attempts_next = attemptsLeft - 1'b1;
        // Win is checked first so the last ship found on the last attempt still wins.
        if (hit_count_next == total_ships) next_state = WIN;
        else if (attempts_next == '0)      next_state = LOSE;
        else                               next_state = PLAY;
      end
      WIN: begin
        win = 1'b1;
        if (confirm_edge) next_state = SETUP;
      end
      LOSE: begin
        lose = 1'b1;
        if (confirm_edge) next_state = SETUP;
      end
      default: next_state = SETUP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= SETUP;
      confirm_prev  <= 1'b0;
      attack_prev   <= 1'b0;
      mapCode       <= 3'b000;
      hitMap        <= '0;
      missMap       <= '0;
      hitCount      <= '0;
      attemptsLeft  <= ATTEMPT_WIDTH'(MAX_ATTEMPTS);
      total_ships   <= '0;
      idx           <= '0;
      repeat_q      <= 1'b0;
      lastHit       <= 1'b0;
      lastMiss      <= 1'b0;
      invalidAttack <= 1'b0;
    end else begin
      state         <= next_state;
      confirm_prev  <= confirm;
      attack_prev   <= attackButton;
      lastHit       <= 1'b0;
      lastMiss      <= 1'b0;
      invalidAttack <= reject_attack;
      if (start_round) begin
        mapCode      <= codeInput;
        hitMap       <= '0;
        missMap      <= '0;
        hitCount     <= '0;
        attemptsLeft <= ATTEMPT_WIDTH'(MAX_ATTEMPTS);
      end
      if (state == LOAD) total_ships <= zero_count;
      if (accept_attack) begin
        idx <= attack_idx;
`ifdef REPEAT_ATTACK_PENALTY_EN
        repeat_q <= already_set;
`else
        repeat_q <= 1'b0;
`endif
      end
      if (state == RESOLVE) begin
        hitCount     <= hit_count_next;
        attemptsLeft <= attempts_next;
        if (resolve_hit) begin
          hitMap[idx] <= 1'b1;
          lastHit     <= 1'b1;
        end else begin
          lastMiss <= 1'b1;
          if (!repeat_q) missMap[idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed rounds plus random maps and attacks,
// compared against a cell-level model of the game rules.
module tb_game_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  codeInput, column, row;
  logic        confirm, attackButton;
  logic [34:0] mapIn;
  logic [2:0]  mapCode;
  logic        mapEnable, playing, win, lose, lastHit, lastMiss, invalidAttack;
  logic [34:0] hitMap, missMap;
  logic [3:0]  attemptsLeft;
  logic [5:0]  hitCount;

  int checks = 0;
  int errors = 0;

  // Model of the round, tracked per cell.
  logic [2:0]  m_code;
  logic [34:0] m_hit, m_miss;
  int          m_hits, m_left, m_total;
  logic        m_enabled, m_playing, m_won, m_lost, m_lh, m_lm, m_inv;

  game_controller dut (
    .clk(clk), .reset(reset), .codeInput(codeInput), .confirm(confirm),
    .attackButton(attackButton), .column(column), .row(row), .mapIn(mapIn),
    .mapCode(mapCode), .mapEnable(mapEnable), .hitMap(hitMap), .missMap(missMap),
    .attemptsLeft(attemptsLeft), .hitCount(hitCount), .playing(playing), .win(win),
    .lose(lose), .lastHit(lastHit), .lastMiss(lastMiss), .invalidAttack(invalidAttack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mapCode"},       64'(mapCode),       64'(m_code));
    check({tag, ".mapEnable"},     64'(mapEnable),     64'(m_enabled));
    check({tag, ".hitMap"},        64'(hitMap),        64'(m_hit));
    check({tag, ".missMap"},       64'(missMap),       64'(m_miss));
    check({tag, ".attemptsLeft"},  64'(attemptsLeft),  64'(m_left));
    check({tag, ".hitCount"},      64'(hitCount),      64'(m_hits));
    check({tag, ".playing"},       64'(playing),       64'(m_playing));
    check({tag, ".win"},           64'(win),           64'(m_won));
    check({tag, ".lose"},          64'(lose),          64'(m_lost));
    check({tag, ".lastHit"},       64'(lastHit),       64'(m_lh));
    check({tag, ".lastMiss"},      64'(lastMiss),      64'(m_lm));
    check({tag, ".invalidAttack"}, 64'(invalidAttack), 64'(m_inv));
  endtask

  task automatic model_reset();
    m_code = 3'b000; m_hit = '0; m_miss = '0; m_hits = 0; m_left = 10; m_total = 0;
    m_enabled = 0; m_playing = 0; m_won = 0; m_lost = 0; m_lh = 0; m_lm = 0; m_inv = 0;
  endtask

  task automatic start_round(input logic [2:0] code, input string tag);
    codeInput = code;
    confirm = 1'b1;
    tick();
    m_code = code; m_hit = '0; m_miss = '0; m_hits = 0; m_left = 10; m_enabled = 1;
    check_all({tag, ".load"});
    confirm = 1'b0;
    tick();
    m_total = 0;
    for (int i = 0; i < 35; i++) if (!mapIn[i]) m_total++;
    if (m_total == 0) m_won = 1; else m_playing = 1;
    check_all({tag, ".begin"});
  endtask

  task automatic end_round(input string tag);
    confirm = 1'b1;
    tick();
    m_playing = 0; m_won = 0; m_lost = 0; m_enabled = 0;
    check_all({tag, ".setup"});
    confirm = 1'b0;
    tick();
    check_all({tag, ".idle"});
  endtask

  task automatic attack(input int col, input int rw, input string tag);
    logic invalid, rep, ship;
    int   pix;
    column = 3'(col);
    row = 3'(rw);
    attackButton = 1'b1;
    tick();
    if (!m_playing) begin
      check_all({tag, ".ignored"});
      attackButton = 1'b0;
      tick();
      check_all({tag, ".ignored2"});
      return;
    end
    invalid = (col > 4) || (rw == 0);
    rep = 0;
    pix = 0;
    if (!invalid) begin
      pix = col * 7 + rw - 1;
      if (m_hit[pix] || m_miss[pix]) begin
`ifdef REPEAT_ATTACK_PENALTY_EN
        rep = 1;
`else
        invalid = 1;
`endif
      end
    end
    if (invalid) begin
      m_inv = 1;
      check_all({tag, ".invalid"});
      m_inv = 0;
      attackButton = 1'b0;
      tick();
      check_all({tag, ".invalid_done"});
      return;
    end
    check({tag, ".resolve_playing"}, 64'(playing), 64'(0));
    check({tag, ".resolve_pulse"},   64'({lastHit, lastMiss, invalidAttack}), 64'(0));
    attackButton = 1'b0;
    tick();
    ship = !mapIn[pix] && !rep;
    if (ship) begin
      m_hit[pix] = 1'b1; m_hits++; m_lh = 1;
    end else begin
      m_lm = 1;
      if (!rep) m_miss[pix] = 1'b1;
      if (m_left > 0) m_left--;
    end
    m_playing = 0;
    if (m_hits == m_total) m_won = 1;
    else if (m_left == 0)  m_lost = 1;
    else                   m_playing = 1;
    check_all({tag, ".result"});
    m_lh = 0;
    m_lm = 0;
  endtask

  initial begin
    int n;
    reset = 1'b0; confirm = 1'b0; attackButton = 1'b0;
    codeInput = 3'b000; column = 3'd0; row = 3'd0; mapIn = '1;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    check_all("reset");

    // Directed round: ships at (a,1) and (b,2).
    mapIn = '1;
    mapIn[0] = 1'b0;
    mapIn[8] = 1'b0;
    start_round(3'b101, "start");
    confirm = 1'b1;
    tick();
    check_all("confirm_in_play");
    confirm = 1'b0;
    tick();
    attack(0, 1, "win_hit1");
    attack(1, 2, "win_hit2");
    attack(2, 2, "after_win");
    end_round("win_end");

    start_round(3'b011, "round2");
    attack(5, 3, "bad_column");
    attack(3, 0, "bad_row");
    attack(0, 1, "hit_a1");
    attack(0, 1, "repeat_a1");
    n = 1;
    while (m_playing && n < 35) begin
      if (n != 8) attack(n / 7, n % 7 + 1, $sformatf("miss_%0d", n));
      n++;
    end
    check("lose_reached", 64'(lose), 64'(1));
    end_round("lose_end");

    // Reset while the attack is being resolved.
    start_round(3'b110, "round3");
    column = 3'd2; row = 3'd3; attackButton = 1'b1;
    tick();
    check("mid_resolve_playing", 64'(playing), 64'(0));
    reset = 1'b0;
    attackButton = 1'b0;
    tick();
    model_reset();
    check_all("mid_reset");
    reset = 1'b1;
    tick();
    check_all("mid_reset_hold");

    // Random rounds against the model.
    for (int r = 0; r < 8; r++) begin
      int ships;
      mapIn = '1;
      ships = $urandom_range(0, 5);
      for (int s = 0; s < ships; s++) mapIn[$urandom_range(0, 34)] = 1'b0;
      start_round(3'($urandom_range(0, 7)), $sformatf("rnd%0d", r));
      for (int a = 0; a < 40 && m_playing; a++) begin
        int c, w, p;
        if ($urandom_range(0, 1) == 1) begin
          p = $urandom_range(0, 34);
          for (int k = 0; k < 35; k++) if (!mapIn[(p + k) % 35] && !m_hit[(p + k) % 35]) begin
            p = (p + k) % 35;
            break;
          end
          c = p / 7;
          w = p % 7 + 1;
        end else begin
          c = $urandom_range(0, 7);
          w = $urandom_range(0, 7);
        end
        attack(c, w, $sformatf("rnd%0d_atk%0d", r, a));
      end
      if (m_won || m_lost) end_round($sformatf("rnd%0d_end", r));
      else begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        check_all($sformatf("rnd%0d_reset", r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
